// File: rtl/control_config_cursor.sv
// Configuration-mode sequencer for the clock/date/timer on-screen UI: mode and cursor
// tracking, field inc/dec strobes, commit on exit, inactivity timeout and cursor blink gate.
module control_config_cursor #(
   parameter int unsigned TIMEOUT_CYCLES = 600000000,
   parameter int unsigned BLINK_HALF     = 25000000,
   parameter int unsigned CNT_W          = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [1:0] config_mode,
   output logic [1:0] cursor_location,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       commit_pulse,
   output logic       cursor_visible
);

   typedef enum logic [1:0] {
      StNormal = 2'd0,
      StHora   = 2'd1,
      StFecha  = 2'd2,
      StTimer  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] TmoLast   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_HALF - 1);

   state_e           state_q, state_d;
   logic [1:0]       cursor_q, cursor_d;
   logic             inc_q, inc_d;
   logic             dec_q, dec_d;
   logic             commit_q, commit_d;
   logic             vis_q, vis_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] blink_q, blink_d;

   logic       any_btn;
   logic       timeout_hit;
   logic [1:0] cursor_max;

   assign any_btn     = btn_mode | btn_left | btn_right | btn_up | btn_down;
   assign timeout_hit = (state_q != StNormal) && !any_btn && (tmo_q == TmoLast);
   assign cursor_max  = (state_q == StTimer) ? 2'd2 : 2'd3;

   // Priority: btn_mode, then timeout, then cursor moves, then field strobes.
   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      inc_d    = 1'b0;
      dec_d    = 1'b0;
      commit_d = 1'b0;
      if (btn_mode) begin
         state_d  = state_e'(state_q + 2'd1);
         commit_d = (state_q != StNormal);
         cursor_d = (state_d == StNormal) ? 2'd0 : 2'd2;
      end else if (timeout_hit) begin
         state_d  = StNormal;
         commit_d = 1'b1;
         cursor_d = 2'd0;
      end else if (state_q != StNormal) begin
         if (btn_left && !btn_right) begin
            cursor_d = (cursor_q == cursor_max) ? 2'd0 : cursor_q + 2'd1;
         end else if (btn_right && !btn_left) begin
            cursor_d = (cursor_q == 2'd0) ? cursor_max : cursor_q - 2'd1;
         end
         inc_d = btn_up && !btn_down;
         dec_d = btn_down && !btn_up;
      end
   end

   always_comb begin
      tmo_d   = tmo_q + CNT_W'(1);
      blink_d = blink_q + CNT_W'(1);
      vis_d   = vis_q;
      if ((state_q == StNormal) || any_btn || timeout_hit) begin
         tmo_d = '0;
      end
      // Any activity or a return to normal shows the cursor solid and restarts the blink.
      if ((state_d == StNormal) || any_btn) begin
         blink_d = '0;
         vis_d   = 1'b1;
      end else if (blink_q == BlinkLast) begin
         blink_d = '0;
         vis_d   = !vis_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StNormal;
         cursor_q <= 2'd0;
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         commit_q <= 1'b0;
         vis_q    <= 1'b1;
         tmo_q    <= '0;
         blink_q  <= '0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         commit_q <= commit_d;
         vis_q    <= vis_d;
         tmo_q    <= tmo_d;
         blink_q  <= blink_d;
      end
   end

   assign config_mode     = state_q;
   assign cursor_location = cursor_q;
   assign inc_pulse       = inc_q;
   assign dec_pulse       = dec_q;
   assign commit_pulse    = commit_q;
   assign cursor_visible  = vis_q;

endmodule

// File: tb/tb_control_config_cursor.sv
// Bench for control_config_cursor: table of per-cycle vectors plus hand-built timeout and
// blink sequences, all checked through an expected-value queue.
module tb_control_config_cursor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [1:0] config_mode;
   logic [1:0] cursor_location;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       commit_pulse;
   logic       cursor_visible;

   localparam logic [5:0] I0  = 6'b000000;
   localparam logic [5:0] RST = 6'b100000;
   localparam logic [5:0] MD  = 6'b010000;
   localparam logic [5:0] LF  = 6'b001000;
   localparam logic [5:0] RT  = 6'b000100;
   localparam logic [5:0] UP  = 6'b000010;
   localparam logic [5:0] DN  = 6'b000001;

   control_config_cursor #(
      .TIMEOUT_CYCLES(20),
      .BLINK_HALF    (4),
      .CNT_W         (30)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_mode       (btn_mode),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_up         (btn_up),
      .btn_down       (btn_down),
      .config_mode    (config_mode),
      .cursor_location(cursor_location),
      .inc_pulse      (inc_pulse),
      .dec_pulse      (dec_pulse),
      .commit_pulse   (commit_pulse),
      .cursor_visible (cursor_visible)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [5:0] in;
      int         mode;
      int         cur;
      int         inc;
      int         dec;
      int         com;
      int         vis;
      int         vis_care;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input string nm, input logic [5:0] in, input int m, input int c,
                      input int i, input int d, input int cm, input int v, input int care);
      vec_t r;
      r.name = nm; r.in = in; r.mode = m; r.cur = c; r.inc = i; r.dec = d;
      r.com = cm; r.vis = v; r.vis_care = care;
      tbl.push_back(r);
   endtask

   task automatic check_out();
      vec_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(config_mode) != e.mode || int'(cursor_location) != e.cur ||
          int'(inc_pulse) != e.inc || int'(dec_pulse) != e.dec ||
          int'(commit_pulse) != e.com || (e.vis_care != 0 && int'(cursor_visible) != e.vis)) begin
         n_bad++;
         $display("FAIL %s: got mode=%0d cur=%0d inc=%0b dec=%0b commit=%0b vis=%0b; want mode=%0d cur=%0d inc=%0d dec=%0d commit=%0d vis=%0d(care=%0d)",
                  e.name, config_mode, cursor_location, inc_pulse, dec_pulse, commit_pulse,
                  cursor_visible, e.mode, e.cur, e.inc, e.dec, e.com, e.vis, e.vis_care);
      end
   endtask

   // One cycle: drive inputs at negedge, queue the expectation, check just after posedge.
   task automatic step(input string nm, input logic [5:0] in, input int m, input int c,
                       input int i, input int d, input int cm, input int v, input int care);
      vec_t r;
      @(negedge clk);
      {reset, btn_mode, btn_left, btn_right, btn_up, btn_down} = in;
      r.name = nm; r.in = in; r.mode = m; r.cur = c; r.inc = i; r.dec = d;
      r.com = cm; r.vis = v; r.vis_care = care;
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      // Mode walk with commits on exits only.
      add("reset", RST, 0, 0, 0, 0, 0, 1, 1);
      add("normal_idle", I0, 0, 0, 0, 0, 0, 1, 1);
      add("enter_hora", MD, 1, 2, 0, 0, 0, 1, 1);
      for (int k = 0; k < 4; k++) add("hora_idle", I0, 1, 2, 0, 0, 0, 0, 0);
      add("hora_to_fecha", MD, 2, 2, 0, 0, 1, 1, 1);
      for (int k = 0; k < 4; k++) add("fecha_idle", I0, 2, 2, 0, 0, 0, 0, 0);
      add("fecha_to_timer", MD, 3, 2, 0, 0, 1, 1, 1);
      for (int k = 0; k < 4; k++) add("timer_idle", I0, 3, 2, 0, 0, 0, 0, 0);
      add("timer_to_normal", MD, 0, 0, 0, 0, 1, 1, 1);
      add("normal_after_exit", I0, 0, 0, 0, 0, 0, 1, 1);
      // Cursor wrapping per mode.
      add("t2_hora", MD, 1, 2, 0, 0, 0, 1, 1);
      add("t2_fecha", MD, 2, 2, 0, 0, 1, 1, 1);
      add("t2_timer", MD, 3, 2, 0, 0, 1, 1, 1);
      add("timer_left_wrap", LF, 3, 0, 0, 0, 0, 1, 1);
      add("timer_right_wrap", RT, 3, 2, 0, 0, 0, 1, 1);
      add("timer_right", RT, 3, 1, 0, 0, 0, 1, 1);
      add("left_right_cancel", LF | RT, 3, 1, 0, 0, 0, 1, 1);
      add("t2_normal", MD, 0, 0, 0, 0, 1, 1, 1);
      add("t2_hora2", MD, 1, 2, 0, 0, 0, 1, 1);
      add("hora_left", LF, 1, 3, 0, 0, 0, 1, 1);
      add("hora_left_wrap", LF, 1, 0, 0, 0, 0, 1, 1);
      // Field strobes.
      add("t3_fecha", MD, 2, 2, 0, 0, 1, 1, 1);
      add("fecha_right", RT, 2, 1, 0, 0, 0, 1, 1);
      add("fecha_up", UP, 2, 1, 1, 0, 0, 1, 1);
      add("inc_one_cycle", I0, 2, 1, 0, 0, 0, 0, 0);
      add("up_down_cancel", UP | DN, 2, 1, 0, 0, 0, 1, 1);
      add("fecha_down", DN, 2, 1, 0, 1, 0, 1, 1);
      add("left_up_tagged", LF | UP, 2, 2, 1, 0, 0, 1, 1);
      add("t3_timer", MD, 3, 2, 0, 0, 1, 1, 1);
      add("t3_normal", MD, 0, 0, 0, 0, 1, 1, 1);
      add("normal_up", UP, 0, 0, 0, 0, 0, 1, 1);
      add("normal_down", DN, 0, 0, 0, 0, 0, 1, 1);
      add("normal_left", LF, 0, 0, 0, 0, 0, 1, 1);
      add("normal_right", RT, 0, 0, 0, 0, 0, 1, 1);
      // Priority and reset abandon.
      add("t6_hora", MD, 1, 2, 0, 0, 0, 1, 1);
      add("mode_beats_left_up", MD | LF | UP, 2, 2, 0, 0, 1, 1, 1);
      add("t6_right", RT, 2, 1, 0, 0, 0, 1, 1);
      add("t6_up", UP, 2, 1, 1, 0, 0, 1, 1);
      add("reset_mid_fecha", RST | MD | UP, 0, 0, 0, 0, 0, 1, 1);
      add("after_reset", I0, 0, 0, 0, 0, 0, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].name, tbl[i].in, tbl[i].mode, tbl[i].cur, tbl[i].inc, tbl[i].dec,
              tbl[i].com, tbl[i].vis, tbl[i].vis_care);
      end

      // Timeout: entry edge plus 19 idle edges stay in mode, the 20th exits with commit.
      step("t4_enter", MD, 1, 2, 0, 0, 0, 1, 1);
      for (int k = 1; k <= 19; k++) step("t4_wait", I0, 1, 2, 0, 0, 0, 0, 0);
      step("t4_timeout", I0, 0, 0, 0, 0, 1, 1, 1);
      step("t4_after", I0, 0, 0, 0, 0, 0, 1, 1);
      // A pulse on idle cycle 18 restarts the count.
      step("t4_enter2", MD, 1, 2, 0, 0, 0, 1, 1);
      for (int k = 1; k <= 17; k++) step("t4_wait2", I0, 1, 2, 0, 0, 0, 0, 0);
      step("t4_restart_up", UP, 1, 2, 1, 0, 0, 1, 1);
      for (int k = 1; k <= 19; k++) step("t4_wait3", I0, 1, 2, 0, 0, 0, 0, 0);
      step("t4_timeout2", I0, 0, 0, 0, 0, 1, 1, 1);

      // Blink: four cycles visible, four hidden; a button restores visibility and restarts.
      step("t5_enter", MD, 1, 2, 0, 0, 0, 1, 1);
      for (int k = 1; k <= 6; k++)
         step("t5_blink", I0, 1, 2, 0, 0, 0, ((k / 4) % 2 == 0) ? 1 : 0, 1);
      step("t5_right_unblank", RT, 1, 1, 0, 0, 0, 1, 1);
      for (int k = 1; k <= 9; k++)
         step("t5_blink2", I0, 1, 1, 0, 0, 0, ((k / 4) % 2 == 0) ? 1 : 0, 1);
      step("t5_exit", MD, 2, 2, 0, 0, 1, 1, 1);
      step("t5_timer", MD, 3, 2, 0, 0, 1, 1, 1);
      step("t5_normal", MD, 0, 0, 0, 0, 1, 1, 1);
      step("t5_normal_idle", I0, 0, 0, 0, 0, 0, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
